// File: rtl/rowcache_pkg.sv
// Shared types and default sizing for the row-cache scheduler.
package rowcache_pkg;

   localparam int unsigned NENT = 32;
   localparam int unsigned ROWW = 17;
   localparam int unsigned IDXW = $clog2(NENT);

   typedef struct packed {
      logic            valid;
      logic            dirty;
      logic [ROWW-1:0] row;
   } cache_tag_t;

   typedef enum logic [2:0] {
      StIdle,
      StLookup,
      StEvict,
      StFill,
      StResp
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or above ptr_i, with wrap.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PTRW-1:0] ptr_i,
   output logic            gnt_valid_o,
   output logic [NREQ-1:0] gnt_o,
   output logic [PTRW-1:0] gnt_idx_o
);

   always_comb begin
      logic [PTRW-1:0] idx;
      idx         = '0;
      gnt_valid_o = 1'b0;
      gnt_o       = '0;
      gnt_idx_o   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = PTRW'((32'(ptr_i) + k) % NREQ);
         if (!gnt_valid_o && req_i[idx]) begin
            gnt_valid_o = 1'b1;
            gnt_o[idx]  = 1'b1;
            gnt_idx_o   = idx;
         end
      end
   end

endmodule

// File: rtl/rowcache_sched.sv
// Row-cache tag scheduler: arbitrates bank requests, looks up a fully-associative
// tag array and sequences victim writeback / row fetch on a miss.
module rowcache_sched
   import rowcache_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_wr,
   input  logic [NREQ*ROWW-1:0] req_row,
   output logic [NREQ-1:0]      done,
   output logic [IDXW-1:0]      rsp_idx,
   output logic                 rsp_hit,
   output logic                 mem_cmd_valid,
   output logic                 mem_cmd_wb,
   output logic [ROWW-1:0]      mem_cmd_row,
   output logic [IDXW-1:0]      mem_cmd_idx,
   input  logic                 mem_ack,
   output logic                 busy
);

   localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e          state_q, state_d;
   cache_tag_t      tags_q [NENT];
   cache_tag_t      tags_d [NENT];
   logic [PTRW-1:0] ptr_q, ptr_d;
   logic [PTRW-1:0] grant_q, grant_d;
   logic [NREQ-1:0] gnt_oh_q, gnt_oh_d;
   logic            wr_q, wr_d;
   logic [ROWW-1:0] row_q, row_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [IDXW-1:0] vptr_q, vptr_d;
   logic            hit_q, hit_d;

   logic            gnt_valid;
   logic [NREQ-1:0] gnt_oh;
   logic [PTRW-1:0] gnt_idx;

   rr_arbiter #(
      .NREQ (NREQ),
      .PTRW (PTRW)
   ) u_arb (
      .req_i       (req_valid),
      .ptr_i       (ptr_q),
      .gnt_valid_o (gnt_valid),
      .gnt_o       (gnt_oh),
      .gnt_idx_o   (gnt_idx)
   );

   logic            hit_any, free_any;
   logic [IDXW-1:0] hit_idx, free_idx, victim;

   // Descending scan so the lowest matching / lowest free index wins.
   always_comb begin
      hit_any  = 1'b0;
      hit_idx  = '0;
      free_any = 1'b0;
      free_idx = '0;
      for (int i = int'(NENT) - 1; i >= 0; i--) begin
         if (tags_q[i].valid && (tags_q[i].row == row_q)) begin
            hit_any = 1'b1;
            hit_idx = IDXW'(i);
         end
         if (!tags_q[i].valid) begin
            free_any = 1'b1;
            free_idx = IDXW'(i);
         end
      end
   end

   assign victim = free_any ? free_idx : vptr_q;

   always_comb begin
      state_d  = state_q;
      tags_d   = tags_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      gnt_oh_d = gnt_oh_q;
      wr_d     = wr_q;
      row_d    = row_q;
      idx_d    = idx_q;
      vptr_d   = vptr_q;
      hit_d    = hit_q;

      done          = '0;
      rsp_idx       = '0;
      rsp_hit       = 1'b0;
      mem_cmd_valid = 1'b0;
      mem_cmd_wb    = 1'b0;
      mem_cmd_row   = '0;
      mem_cmd_idx   = '0;
      busy          = (state_q != StIdle);

      unique case (state_q)
         StIdle: begin
            if (gnt_valid) begin
               grant_d  = gnt_idx;
               gnt_oh_d = gnt_oh;
               wr_d     = |(req_wr & gnt_oh);
               row_d    = req_row[32'(gnt_idx) * ROWW +: ROWW];
               state_d  = StLookup;
            end
         end
         StLookup: begin
            if (hit_any) begin
               idx_d = hit_idx;
               hit_d = 1'b1;
               if (wr_q) tags_d[hit_idx].dirty = 1'b1;
               state_d = StResp;
            end else begin
               idx_d = victim;
               hit_d = 1'b0;
               if (!free_any) vptr_d = vptr_q + 1'b1;
               state_d = (tags_q[victim].valid && tags_q[victim].dirty) ? StEvict : StFill;
            end
         end
         StEvict: begin
            mem_cmd_valid = 1'b1;
            mem_cmd_wb    = 1'b1;
            mem_cmd_row   = tags_q[idx_q].row;
            mem_cmd_idx   = idx_q;
            if (mem_ack) state_d = StFill;
         end
         StFill: begin
            mem_cmd_valid = 1'b1;
            mem_cmd_row   = row_q;
            mem_cmd_idx   = idx_q;
            if (mem_ack) begin
               tags_d[idx_q].valid = 1'b1;
               tags_d[idx_q].dirty = wr_q;
               tags_d[idx_q].row   = row_q;
               state_d             = StResp;
            end
         end
         StResp: begin
            done    = gnt_oh_q;
            rsp_idx = idx_q;
            rsp_hit = hit_q;
            ptr_d   = (grant_q == PTRW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         grant_q  <= '0;
         gnt_oh_q <= '0;
         wr_q     <= 1'b0;
         row_q    <= '0;
         idx_q    <= '0;
         vptr_q   <= '0;
         hit_q    <= 1'b0;
         for (int i = 0; i < int'(NENT); i++) tags_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         gnt_oh_q <= gnt_oh_d;
         wr_q     <= wr_d;
         row_q    <= row_d;
         idx_q    <= idx_d;
         vptr_q   <= vptr_d;
         hit_q    <= hit_d;
         tags_q   <= tags_d;
      end
   end

endmodule

// File: tb/tb_rowcache_sched.sv
// Self-checking bench for rowcache_sched against a behavioural cache/arbiter model.
module tb_rowcache_sched;

   localparam int NREQ = 4;
   localparam int NENT = 32;
   localparam int ROWW = 17;
   localparam int IDXW = 5;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_wr = '0;
   logic [NREQ*ROWW-1:0] req_row = '0;
   logic [NREQ-1:0]      done;
   logic [IDXW-1:0]      rsp_idx;
   logic                 rsp_hit;
   logic                 mem_cmd_valid;
   logic                 mem_cmd_wb;
   logic [ROWW-1:0]      mem_cmd_row;
   logic [IDXW-1:0]      mem_cmd_idx;
   logic                 mem_ack = 1'b0;
   logic                 busy;

   rowcache_sched #(
      .NREQ (NREQ)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_wr        (req_wr),
      .req_row       (req_row),
      .done          (done),
      .rsp_idx       (rsp_idx),
      .rsp_hit       (rsp_hit),
      .mem_cmd_valid (mem_cmd_valid),
      .mem_cmd_wb    (mem_cmd_wb),
      .mem_cmd_row   (mem_cmd_row),
      .mem_cmd_idx   (mem_cmd_idx),
      .mem_ack       (mem_ack),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: cache contents, victim pointer and round-robin pointer.
   bit              m_valid [NENT];
   bit              m_dirty [NENT];
   logic [ROWW-1:0] m_row   [NENT];
   int              m_vptr;
   int              m_ptr;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({done, rsp_idx, rsp_hit, mem_cmd_valid, mem_cmd_wb, mem_cmd_row,
                  mem_cmd_idx, busy});
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NENT; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_row[i]   = '0;
      end
      m_vptr = 0;
      m_ptr  = 0;
   endtask

   task automatic set_req(input int i, input logic [ROWW-1:0] row, input bit wr);
      req_valid[i]               = 1'b1;
      req_wr[i]                  = wr;
      req_row[i*ROWW +: ROWW]    = row;
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      req_valid = '0;
      mem_ack   = 1'b0;
      repeat (3) step();
      check_eq("reset_outs", all_outs(), 64'd0);
      rst = 1'b0;
      model_reset();
      step();
   endtask

   // Runs one arbitration from IDLE to the IDLE after the done pulse.
   task automatic serve(input int ev_dly, input int fill_dly, input bit drop, input bit keep);
      int              g;
      int              hit_i;
      int              vict;
      bit              ev;
      logic [ROWW-1:0] r;
      bit              w;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = (m_ptr + k) % NREQ;
         if (g < 0 && req_valid[j]) g = j;
      end
      if (g < 0) begin
         check_eq("serve_no_req", 64'd0, 64'd1);
         return;
      end
      r     = req_row[g*ROWW +: ROWW];
      w     = req_wr[g];
      hit_i = -1;
      vict  = -1;
      ev    = 1'b0;
      for (int i = 0; i < NENT; i++)
         if (hit_i < 0 && m_valid[i] && m_row[i] == r) hit_i = i;
      if (hit_i < 0) begin
         for (int i = 0; i < NENT; i++)
            if (vict < 0 && !m_valid[i]) vict = i;
         if (vict < 0) begin
            vict   = m_vptr;
            m_vptr = (m_vptr + 1) % NENT;
         end
         ev = m_valid[vict] && m_dirty[vict];
      end

      step();  // LOOKUP
      check_eq("lookup_state", 64'({busy, mem_cmd_valid, done}), 64'({1'b1, 1'b0, 4'b0}));
      mem_ack = 1'($urandom_range(0, 1));  // stray ack must be ignored
      step();
      mem_ack = 1'b0;

      if (hit_i >= 0) begin
         check_eq("hit_done", 64'(done), 64'(1) << g);
         check_eq("hit_rsp", 64'({rsp_hit, rsp_idx, mem_cmd_valid}),
                  64'({1'b1, IDXW'(hit_i), 1'b0}));
         if (w) m_dirty[hit_i] = 1'b1;
      end else begin
         if (ev) begin
            check_eq("evict_cmd", 64'({mem_cmd_valid, mem_cmd_wb, mem_cmd_row, mem_cmd_idx}),
                     64'({1'b1, 1'b1, m_row[vict], IDXW'(vict)}));
            repeat (ev_dly) begin
               step();
               check_eq("evict_hold",
                        64'({mem_cmd_valid, mem_cmd_wb, mem_cmd_row, mem_cmd_idx, done}),
                        64'({1'b1, 1'b1, m_row[vict], IDXW'(vict), 4'b0}));
            end
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
         end
         check_eq("fill_cmd", 64'({mem_cmd_valid, mem_cmd_wb, mem_cmd_row, mem_cmd_idx, done}),
                  64'({1'b1, 1'b0, r, IDXW'(vict), 4'b0}));
         if (drop) req_valid[g] = 1'b0;
         repeat (fill_dly) begin
            step();
            check_eq("fill_hold",
                     64'({busy, mem_cmd_valid, mem_cmd_wb, mem_cmd_row, mem_cmd_idx, done}),
                     64'({1'b1, 1'b1, 1'b0, r, IDXW'(vict), 4'b0}));
         end
         mem_ack = 1'b1;
         step();
         mem_ack = 1'b0;
         check_eq("miss_done", 64'(done), 64'(1) << g);
         check_eq("miss_rsp", 64'({rsp_hit, rsp_idx, mem_cmd_valid}),
                  64'({1'b0, IDXW'(vict), 1'b0}));
         m_valid[vict] = 1'b1;
         m_dirty[vict] = w;
         m_row[vict]   = r;
      end
      m_ptr = (g + 1) % NREQ;
      if (!keep) req_valid[g] = 1'b0;
      step();
      check_eq("post_idle", 64'({busy, done}), 64'd0);
   endtask

   initial begin
      model_reset();
      repeat (2) step();
      check_eq("por_outs", all_outs(), 64'd0);
      rst = 1'b0;
      step();

      // First miss then hit on the same row.
      set_req(0, 17'h00123, 1'b0);
      serve(0, 0, 1'b0, 1'b0);
      set_req(0, 17'h00123, 1'b0);
      serve(0, 0, 1'b0, 1'b0);

      // Four simultaneous requests, then the same set again after pointer wrap.
      for (int i = 0; i < NREQ; i++) set_req(i, 17'(17'h200 + i), 1'b0);
      repeat (NREQ) serve(0, 0, 1'b0, 1'b0);
      for (int i = 0; i < NREQ; i++) set_req(i, 17'(17'h200 + i), 1'b0);
      repeat (NREQ) serve(0, 0, 1'b0, 1'b0);

      // Back-to-back re-arbitration of a held request.
      set_req(2, 17'h00123, 1'b1);
      serve(0, 0, 1'b0, 1'b1);
      serve(0, 0, 1'b0, 1'b0);

      // Fill with dirty rows, then force dirty evictions.
      apply_reset();
      for (int i = 0; i < NENT; i++) begin
         set_req(i % NREQ, 17'(i), 1'b1);
         serve(0, 0, 1'b0, 1'b0);
      end
      set_req(0, 17'd40, 1'b0);
      serve(1, 1, 1'b0, 1'b0);
      set_req(1, 17'd41, 1'b0);
      serve(0, 2, 1'b0, 1'b0);

      // Clean fills, a write hit, then an eviction of that now-dirty entry.
      apply_reset();
      for (int i = 0; i < NENT; i++) begin
         set_req(i % NREQ, 17'(100 + i), 1'b0);
         serve(0, 0, 1'b0, 1'b0);
      end
      set_req(0, 17'd200, 1'b0);
      serve(0, 0, 1'b0, 1'b0);
      set_req(1, 17'd101, 1'b1);
      serve(0, 0, 1'b0, 1'b0);
      set_req(2, 17'd201, 1'b0);
      serve(2, 0, 1'b0, 1'b0);

      // Stall in FILL, then reset mid-operation.
      apply_reset();
      set_req(1, 17'h1abcd, 1'b1);
      step();
      step();
      for (int k = 0; k < 10; k++) begin
         check_eq("stall_fill", 64'({busy, mem_cmd_valid, mem_cmd_row, mem_cmd_idx, done}),
                  64'({1'b1, 1'b1, 17'h1abcd, 5'd0, 4'b0}));
         step();
      end
      rst       = 1'b1;
      req_valid = '0;
      step();
      check_eq("midop_reset", all_outs(), 64'd0);
      rst = 1'b0;
      model_reset();
      step();
      set_req(1, 17'h1abcd, 1'b0);
      serve(0, 0, 1'b0, 1'b0);

      // Requester drops during FILL; entry still installed.
      set_req(3, 17'h00777, 1'b1);
      serve(0, 2, 1'b1, 1'b0);
      set_req(3, 17'h00777, 1'b0);
      serve(0, 0, 1'b0, 1'b0);

      // Randomized traffic over a small row pool to mix hits, clean and dirty misses.
      for (int it = 0; it < 120; it++) begin
         logic [NREQ-1:0] mask;
         mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) begin
            if (mask[i]) set_req(i, 17'($urandom_range(0, 47)), 1'($urandom_range(0, 1)));
            else req_valid[i] = 1'b0;
         end
         serve($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 7) == 0), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
